// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the EX/MEM control bundle.
// Imported by every stage that carries control bits down the pipe.
package cpu_pkg;

  localparam int N  = 16;  // datapath width: ALU result, store data, PC
  localparam int RA = 3;   // register-address width
  localparam int WC = 8;   // memory-wait counter width

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic br_eq;
    logic br_ne;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  localparam logic [WC-1:0] WAIT_MAX = '1;
  localparam logic [WC-1:0] WAIT_ONE = WC'(1);

endpackage

// File: rtl/branch_resolve.sv
// Conditional-branch decision from the captured zero flag.
// BEQ is taken on zero and BNE on non-zero, both only for a real instruction.
module branch_resolve (
  input  logic valid,
  input  logic zero,
  input  logic br_eq,
  input  logic br_ne,
  output logic taken
);

  assign taken = valid & ((br_eq & zero) | (br_ne & ~zero));

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: drives data memory, resolves branches,
// stalls the front of the pipe on memory wait, and feeds the forwarding muxes.
module ex_mem_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [N-1:0]  ex_alu_out,
  input  logic          ex_zero,
  input  logic [N-1:0]  ex_store_data,
  input  logic [RA-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_br_eq,
  input  logic          ex_br_ne,
  input  logic [N-1:0]  ex_pc_next,
  input  logic [N-1:0]  ex_br_offset,
  input  logic          flush_in,
  input  logic          mem_ready,
  output logic          em_valid,
  output logic [N-1:0]  em_alu_out,
  output logic [N-1:0]  em_store_data,
  output logic [RA-1:0] em_rd,
  output logic          em_reg_write,
  output logic          em_mem_to_reg,
  output logic          mem_req,
  output logic          mem_we,
  output logic          stall_out,
  output logic          br_taken,
  output logic [N-1:0]  br_target,
  output logic          fwd_valid,
  output logic [RA-1:0] fwd_rd,
  output logic [N-1:0]  fwd_data,
  output logic [WC-1:0] wait_cnt
);

  ctrl_t ex_ctrl;
  ctrl_t ctrl_q;
  logic  zero_q;

  assign ex_ctrl = '{reg_write:  ex_reg_write,
                     mem_read:   ex_mem_read,
                     mem_write:  ex_mem_write,
                     mem_to_reg: ex_mem_to_reg,
                     br_eq:      ex_br_eq,
                     br_ne:      ex_br_ne};

  // Memory handshake: mem_req is the valid and mem_ready the ready. A request
  // completes on the rising edge where both are high; until then the address,
  // store data and mem_we stay stable because the whole stage is held.
  assign mem_req   = em_valid & (ctrl_q.mem_read | ctrl_q.mem_write);
  assign mem_we    = em_valid & ctrl_q.mem_write;
  assign stall_out = mem_req & ~mem_ready;

  branch_resolve u_branch_resolve (
    .valid (em_valid),
    .zero  (zero_q),
    .br_eq (ctrl_q.br_eq),
    .br_ne (ctrl_q.br_ne),
    .taken (br_taken)
  );

  assign em_reg_write  = ctrl_q.reg_write;
  assign em_mem_to_reg = ctrl_q.mem_to_reg;

  // Loads are excluded: their data only exists after memory returns.
  assign fwd_valid = em_valid & ctrl_q.reg_write & ~ctrl_q.mem_read & (em_rd != '0);
  assign fwd_rd    = em_rd;
  assign fwd_data  = em_alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_valid      <= 1'b0;
      em_alu_out    <= '0;
      em_store_data <= '0;
      em_rd         <= '0;
      ctrl_q        <= BUBBLE;
      zero_q        <= 1'b0;
      br_target     <= '0;
    end else if (stall_out) begin
      em_valid <= em_valid;
    end else if (flush_in || br_taken) begin
      em_valid <= 1'b0;
      ctrl_q   <= BUBBLE;
    end else begin
      em_valid      <= ex_valid;
      em_alu_out    <= ex_alu_out;
      em_store_data <= ex_store_data;
      em_rd         <= ex_rd;
      ctrl_q        <= ex_valid ? ex_ctrl : BUBBLE;
      zero_q        <= ex_zero;
      br_target     <= ex_pc_next + ex_br_offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (stall_out && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_ONE;
    end
  end

endmodule
